// File: rtl/keypad_hex_encoder.sv
// Scans a 4x4 active-low matrix keypad, debounces on scan ticks and emits the hex code of each
// accepted press as a nibble with a one-cycle valid pulse.
module keypad_hex_encoder #(
  parameter int unsigned SCAN_DIV       = 100000,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst,
  output logic [3:0] row,
  input  logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_down
);

  localparam int unsigned     DivW       = $clog2(SCAN_DIV);
  localparam int unsigned     CntW       = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DivW-1:0] DivLast    = DivW'(SCAN_DIV - 1);
  localparam logic [CntW-1:0] CntLast    = CntW'(DEBOUNCE_SCANS - 1);
  localparam bit              SingleScan = (DEBOUNCE_SCANS == 1);

  typedef enum logic [1:0] {
    StScan,
    StDebounce,
    StPressed,
    StRelease
  } state_e;

  logic [3:0]      col_meta_q, col_s_q;
  logic [DivW-1:0] div_q;
  logic            tick;
  state_e          state_q;
  logic [1:0]      row_idx_q, row_idx_nxt;
  logic [3:0]      row_q, row_nxt;
  logic [3:0]      cand_col_q;
  logic [CntW-1:0] cnt_q;
  logic [3:0]      key_code_q;
  logic            key_valid_q, key_down_q;
  logic [1:0]      press_col;
  logic [3:0]      press_code;
  logic            col_idle;

  // Two-flop synchroniser; idles high so reset never looks like a press.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_meta_q <= 4'hF;
      col_s_q    <= 4'hF;
    end else begin
      col_meta_q <= col;
      col_s_q    <= col_meta_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= '0;
    end else if (tick) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + DivW'(1);
    end
  end

  assign tick        = (div_q == DivLast);
  assign col_idle    = (col_s_q == 4'hF);
  assign row_idx_nxt = row_idx_q + 2'd1;
  assign row_nxt     = ~(4'b0001 << row_idx_nxt);

  // Lowest-index low column wins when several keys share the driven row.
  always_comb begin
    press_col = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!col_s_q[i]) press_col = 2'(i);
    end
  end

  always_comb begin
    press_code = 4'h0;
    unique case ({row_idx_q, press_col})
      4'b00_00: press_code = 4'h1;
      4'b00_01: press_code = 4'h2;
      4'b00_10: press_code = 4'h3;
      4'b00_11: press_code = 4'hA;
      4'b01_00: press_code = 4'h4;
      4'b01_01: press_code = 4'h5;
      4'b01_10: press_code = 4'h6;
      4'b01_11: press_code = 4'hB;
      4'b10_00: press_code = 4'h7;
      4'b10_01: press_code = 4'h8;
      4'b10_10: press_code = 4'h9;
      4'b10_11: press_code = 4'hC;
      4'b11_00: press_code = 4'h0;
      4'b11_01: press_code = 4'hF;
      4'b11_10: press_code = 4'hE;
      4'b11_11: press_code = 4'hD;
      default:  press_code = 4'h0;
    endcase
  end

  // row_idx stays frozen outside StScan, so it still names the candidate key's row.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StScan;
      row_idx_q   <= 2'd0;
      row_q       <= 4'b1110;
      cand_col_q  <= 4'hF;
      cnt_q       <= '0;
      key_code_q  <= 4'h0;
      key_valid_q <= 1'b0;
      key_down_q  <= 1'b0;
    end else begin
      key_valid_q <= 1'b0;
      if (tick) begin
        unique case (state_q)
          StScan: begin
            if (col_idle) begin
              row_idx_q <= row_idx_nxt;
              row_q     <= row_nxt;
            end else if (SingleScan) begin
              cand_col_q  <= col_s_q;
              state_q     <= StPressed;
              key_code_q  <= press_code;
              key_valid_q <= 1'b1;
              key_down_q  <= 1'b1;
            end else begin
              cand_col_q <= col_s_q;
              cnt_q      <= CntW'(1);
              state_q    <= StDebounce;
            end
          end
          StDebounce: begin
            if (col_s_q != cand_col_q) begin
              state_q   <= StScan;
              cnt_q     <= '0;
              row_idx_q <= row_idx_nxt;
              row_q     <= row_nxt;
            end else if (cnt_q == CntLast) begin
              state_q     <= StPressed;
              cnt_q       <= '0;
              key_code_q  <= press_code;
              key_valid_q <= 1'b1;
              key_down_q  <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CntW'(1);
            end
          end
          StPressed: begin
            if (col_idle) begin
              if (SingleScan) begin
                state_q    <= StScan;
                key_down_q <= 1'b0;
                row_idx_q  <= row_idx_nxt;
                row_q      <= row_nxt;
              end else begin
                state_q <= StRelease;
                cnt_q   <= CntW'(1);
              end
            end
          end
          StRelease: begin
            if (!col_idle) begin
              state_q <= StPressed;
              cnt_q   <= '0;
            end else if (cnt_q == CntLast) begin
              state_q    <= StScan;
              cnt_q      <= '0;
              key_down_q <= 1'b0;
              row_idx_q  <= row_idx_nxt;
              row_q      <= row_nxt;
            end else begin
              cnt_q <= cnt_q + CntW'(1);
            end
          end
          default: state_q <= StScan;
        endcase
      end
    end
  end

  assign row       = row_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_down  = key_down_q;

endmodule
